// File: rtl/ppc_types.sv
// ppc_types
//   Types shared by the trap datapath.
//   trap_ext_decode_t : decoded trap control, the five TO condition enables in
//                       architectural order (to[0] first) plus word_mode, which
//                       selects a 32-bit compare on 64-bit operands.
//   TO_* indices      : position of each condition in both TO and trap_cause.
package ppc_types;

    typedef struct packed {
        logic [0:4] to;
        logic       word_mode;
    } trap_ext_decode_t;

    localparam int TO_SLT = 0;  // signed A < B
    localparam int TO_SGT = 1;  // signed A > B
    localparam int TO_EQ  = 2;  // A == B
    localparam int TO_ULT = 3;  // unsigned A < B
    localparam int TO_UGT = 4;  // unsigned A > B

endpackage

// File: rtl/trap_pipe_compare.sv
// trap_compare
//   Purely combinational trap condition evaluation.
//   Ports:
//     a, b       : operands, big-endian bit numbering (bit 0 = MSB)
//     control    : TO enables and word_mode
//     trap       : OR of all enabled, satisfied conditions
//     trap_cause : per-condition hit vector, same order as TO
module trap_compare
    import ppc_types::*;
#(
    parameter int OP_WIDTH = 64
) (
    input  logic [0:OP_WIDTH-1] a,
    input  logic [0:OP_WIDTH-1] b,
    input  trap_ext_decode_t    control,
    output logic                trap,
    output logic [0:4]          trap_cause
);

    // Operands re-expressed as ordinary numeric vectors, separately for the
    // signed and unsigned tests so word mode can extend them differently.
    logic [OP_WIDTH-1:0] a_s;
    logic [OP_WIDTH-1:0] b_s;
    logic [OP_WIDTH-1:0] a_u;
    logic [OP_WIDTH-1:0] b_u;

    if (OP_WIDTH == 64) begin : g_word
        // In word mode only the low word (big-endian bits 32..63) counts:
        // sign-extend it for the signed tests, zero-extend for the unsigned.
        always_comb begin
            a_s = a;
            b_s = b;
            a_u = a;
            b_u = b;
            if (control.word_mode) begin
                a_s = {{32{a[32]}}, a[32:63]};
                b_s = {{32{b[32]}}, b[32:63]};
                a_u = {32'b0, a[32:63]};
                b_u = {32'b0, b[32:63]};
            end
        end
    end else begin : g_no_word
        // word_mode has no meaning at 32 bits.
        logic unused_word_mode;
        assign unused_word_mode = control.word_mode;

        always_comb begin
            a_s = a;
            b_s = b;
            a_u = a;
            b_u = b;
        end
    end

    always_comb begin
        trap_cause         = '0;
        trap_cause[TO_SLT] = control.to[TO_SLT] && ($signed(a_s) < $signed(b_s));
        trap_cause[TO_SGT] = control.to[TO_SGT] && ($signed(a_s) > $signed(b_s));
        trap_cause[TO_EQ]  = control.to[TO_EQ]  && (a_u == b_u);
        trap_cause[TO_ULT] = control.to[TO_ULT] && (a_u < b_u);
        trap_cause[TO_UGT] = control.to[TO_UGT] && (a_u > b_u);
    end

    assign trap = |trap_cause;

endmodule

// File: rtl/trap_pipe.sv
// trap_pipe
//   Elastic PIPE_DEPTH-stage trap-condition pipeline. Stage 0 registers the
//   operands and control; the compare result is captured into stage 1 and
//   carried to the last stage (for PIPE_DEPTH=1 the result is evaluated from
//   the stage-0 registers). Valid/ready handshakes on both sides.
//   Ports:
//     clk, rst (async, active-low), flush (synchronous kill of all entries)
//     input_valid/input_ready, rs_id_in, op1, op2, control : upstream side
//     output_valid/output_ready, rs_id_out, trap, trap_cause : downstream side
module trap_pipe
    import ppc_types::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int OP_WIDTH    = 64,
    parameter int PIPE_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [RS_ID_WIDTH-1:0] rs_id_in,
    input  logic [0:OP_WIDTH-1]    op1,
    input  logic [0:OP_WIDTH-1]    op2,
    input  trap_ext_decode_t       control,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [RS_ID_WIDTH-1:0] rs_id_out,
    output logic                   trap,
    output logic [0:4]             trap_cause
);

    if (!(OP_WIDTH == 32 || OP_WIDTH == 64)) begin : g_bad_op_width
        $error("trap_pipe: OP_WIDTH must be 32 or 64");
    end
    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_pipe_depth
        $error("trap_pipe: PIPE_DEPTH must be in 1..4");
    end

    logic [PIPE_DEPTH-1:0]  valid_q;
    logic [PIPE_DEPTH-1:0]  adv;
    logic [RS_ID_WIDTH-1:0] tag_q [PIPE_DEPTH];
    logic [0:OP_WIDTH-1]    op1_q;
    logic [0:OP_WIDTH-1]    op2_q;
    trap_ext_decode_t       ctrl_q;

    logic                   cmp_trap;
    logic [0:4]             cmp_cause;

    // {trap, trap_cause} as seen at the output of each stage; element 0 is
    // the live compare of the stage-0 registers.
    logic [5:0]             res_src [PIPE_DEPTH];

    // A stage may load when any stage at or after it is empty, or the
    // consumer is taking the last entry. Accumulating from the tail avoids
    // a self-referencing chain through adv itself.
    always_comb begin
        logic hole;
        adv  = '0;
        hole = output_ready;
        for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
            hole   = hole || !valid_q[i];
            adv[i] = hole;
        end
    end

    assign input_ready = adv[0];

    // Valid bits, tags and stage-0 operands. Flush empties the pipe and
    // drops the same-cycle input; any output handshake that cycle is moot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                tag_q[i] <= '0;
            end
            op1_q  <= '0;
            op2_q  <= '0;
            ctrl_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            if (adv[0]) begin
                valid_q[0] <= input_valid;
                if (input_valid) begin
                    tag_q[0] <= rs_id_in;
                    op1_q    <= op1;
                    op2_q    <= op2;
                    ctrl_q   <= control;
                end
            end
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                if (adv[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        tag_q[i] <= tag_q[i-1];
                    end
                end
            end
        end
    end

    trap_compare #(
        .OP_WIDTH (OP_WIDTH)
    ) u_compare (
        .a          (op1_q),
        .b          (op2_q),
        .control    (ctrl_q),
        .trap       (cmp_trap),
        .trap_cause (cmp_cause)
    );

    assign res_src[0] = {cmp_trap, cmp_cause};

    // Result registers for stages 1..PIPE_DEPTH-1; they only load alongside
    // a valid entry so a stalled or bubbled stage keeps its value.
    for (genvar s = 1; s < PIPE_DEPTH; s++) begin : g_res
        logic [5:0] res_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                res_q <= '0;
            end else if (!flush && adv[s] && valid_q[s-1]) begin
                res_q <= res_src[s-1];
            end
        end

        assign res_src[s] = res_q;
    end

    assign output_valid       = valid_q[PIPE_DEPTH-1];
    assign rs_id_out          = tag_q[PIPE_DEPTH-1];
    assign {trap, trap_cause} = res_src[PIPE_DEPTH-1];

endmodule

// File: doc/trap_pipe.md
TRAP_PIPE -- requirements
Module: trap_pipe

Interface
REQ-001 SHALL have parameter RS_ID_WIDTH, default 5, reservation-station tag width.
REQ-002 SHALL have parameter OP_WIDTH, default 64, operand width; legal values 32 and 64 only.
REQ-003 SHALL have parameter PIPE_DEPTH, default 2, number of register stages; legal range 1..4.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port flush  input  1  synchronous kill of all in-flight entries.
REQ-007 SHALL have port input_valid  input  1  upstream entry present.
REQ-008 SHALL have port input_ready  output  1  entry accepted when input_valid & input_ready.
REQ-009 SHALL have port rs_id_in  input  RS_ID_WIDTH  issuing station tag.
REQ-010 SHALL have port op1  input  OP_WIDTH  operand A, bit 0 = MSB.
REQ-011 SHALL have port op2  input  OP_WIDTH  operand B, bit 0 = MSB.
REQ-012 SHALL have port control  input  trap_ext_decode_t  TO[0:4] plus word_mode.
REQ-013 SHALL have port output_valid  output  1  result present.
REQ-014 SHALL have port output_ready  input  1  downstream consumes when output_valid & output_ready.
REQ-015 SHALL have port rs_id_out  output  RS_ID_WIDTH  tag of the presented result.
REQ-016 SHALL have port trap  output  1  trap condition of the presented result.
REQ-017 SHALL have port trap_cause  output  5  per-TO-bit hit vector, same order as TO.

Function
REQ-018 SHALL compare: TO[0] signed A<B, TO[1] signed A>B, TO[2] A==B, TO[3] unsigned A<B, TO[4] unsigned A>B; trap_cause[i] = condition i AND TO[i]; trap = OR of trap_cause.
REQ-019 SHALL, when word_mode=1 and OP_WIDTH=64, compare bits 32..63 of each operand only, sign-extended for signed and zero-extended for unsigned tests; word_mode is ignored when OP_WIDTH=32.
REQ-020 SHALL be an elastic pipeline: stage i advances when it is empty, or when stage i+1 advances, or (last stage) when output_ready=1.
REQ-021 SHALL drive input_ready = NOT valid[0] OR advance[1] (advance[1] = output_ready for PIPE_DEPTH=1), independent of input_valid.
REQ-022 SHALL present a result exactly PIPE_DEPTH cycles after acceptance when output_ready stays 1, sustaining one result per cycle.
REQ-023 SHALL register operands at stage 0 and produce trap/trap_cause into the last stage; comparison logic SHALL NOT depend combinationally on op1/op2/control ports.
REQ-024 SHALL hold output_valid, rs_id_out, trap, trap_cause stable while output_valid=1 and output_ready=0.
REQ-025 SHALL, on flush=1, clear every valid bit at the next edge, ignore input_valid that cycle, and treat a same-cycle output handshake as not consumed.
REQ-026 SHALL preserve entry order; no entry dropped or duplicated except by flush.

Reset
REQ-027 SHALL, while rst=0, asynchronously clear all valid bits, tags, operands, control, trap and trap_cause to 0.
REQ-028 SHALL drive output_valid=0, trap=0, trap_cause=0, rs_id_out=0 during reset; input_ready=1 in the first cycle after release.
REQ-029 SHALL discard any entry in flight when reset asserts mid-operation.

Structure
REQ-030 SHALL take trap_ext_decode_t (TO[0:4], word_mode) from shared package ppc_types.
REQ-031 SHALL isolate the comparison in combinational sub-module trap_compare (parameter OP_WIDTH; outputs trap, trap_cause).
REQ-032 SHALL reject illegal OP_WIDTH/PIPE_DEPTH at elaboration.

Verification
REQ-033 SHALL cover: OP_WIDTH=64, A=-1, B=1, TO=10000 -> trap=1, cause=10000, exactly 2 cycles after accept.
REQ-034 SHALL cover: A=-1, B=1, TO=00001 -> trap=1, cause=00001; TO=00010 -> trap=0.
REQ-035 SHALL cover: word_mode=1, A=0x1_00000005, B=0x2_00000005, TO=00100 -> trap=1; word_mode=0 -> trap=0.
REQ-036 SHALL cover: 4 back-to-back entries, output_ready=0 for 3 cycles -> input_ready=0 after 2 accepts, outputs frozen, tags 1..4 in order, no loss.
REQ-037 SHALL cover: flush with 2 entries in flight and input_valid=1 -> output_valid=0 next cycle, input not accepted, no later result.
REQ-038 SHALL cover: rst=0 asserted mid-stream between edges -> output_valid=0 immediately; release -> input_ready=1, next result is first post-reset entry.
